kmkz_regfile_np: RTL and testbench

Parametrised successor of the two-read-port `urv_regfile` for the Kamikaze-uRV core, sitting between decode (D) and execute (X).
- Configurable data width, register count and number of read ports.
- Keeps the registered-read plus X/W forwarding scheme.
- Adds a post-reset clear sequencer, so no register is uninitialised in ASIC builds.
- Adds a debug read/write port with a req/ack handshake, used while the core is halted.

---
 rtl/kmkz_regfile_np.sv | 140 ++++++++++++++
 tb/tb_kmkz_regfile_np.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmkz_regfile_np.sv
// kmkz_regfile_np: parametrised Kamikaze-uRV register file between D and X.
// Registered reads with X/W forwarding, post-reset clear and a debug port.
module kmkz_regfile_np #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               d_stall_i,
   input  logic [NRD*AW-1:0]  rf_rs_i,
   input  logic [NRD*AW-1:0]  d_rs_i,
   output logic [NRD*XLEN-1:0] x_rs_value_o,
   input  logic [AW-1:0]      w_rd_i,
   input  logic [XLEN-1:0]    w_rd_value_i,
   input  logic               w_rd_store_i,
   input  logic               w_bypass_rd_write_i,
   input  logic [XLEN-1:0]    w_bypass_rd_value_i,
   input  logic               dbg_req_i,
   input  logic               dbg_we_i,
   input  logic [AW-1:0]      dbg_addr_i,
   input  logic [XLEN-1:0]    dbg_wdata_i,
   output logic               dbg_ack_o,
   output logic [XLEN-1:0]    dbg_rdata_o,
   output logic               init_busy_o
);

   typedef enum logic [1:0] {INIT, RUN, DBG_RD, DBG_ACK} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q;
   logic [AW-1:0]   dbg_addr_q;
   logic [XLEN-1:0] dbg_rdata_q;
   logic [XLEN-1:0] ram [NREGS];
   logic [XLEN-1:0] rd_q [NRD];
   logic [NRD-1:0]  fw_w_q;
   logic [XLEN-1:0] bypass_w_q;
   logic            wr;
   logic            dbg_acc;
   logic            ram_we;
   logic [AW-1:0]   ram_wa;
   logic [XLEN-1:0] ram_wd;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign wr      = w_rd_store_i && !is_zero(w_rd_i) && (state_q != INIT);
   assign dbg_acc = (state_q == RUN) && dbg_req_i && d_stall_i && !wr;

   // Next-state logic: clear sweep, then idle/debug handshake
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT:    if (cnt_q == AW'(NREGS - 1)) state_d = RUN;
         RUN:     if (dbg_acc) state_d = dbg_we_i ? DBG_ACK : DBG_RD;
         DBG_RD:  state_d = DBG_ACK;
         DBG_ACK: state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   // Single RAM write port: clear sweep, then pipeline, then debug
   always_comb begin
      ram_we = 1'b0;
      ram_wa = w_rd_i;
      ram_wd = w_rd_value_i;
      if (state_q == INIT) begin
         ram_we = 1'b1;
         ram_wa = cnt_q;
         ram_wd = '0;
      end else if (wr) begin
         ram_we = 1'b1;
      end else if (dbg_acc && dbg_we_i && !is_zero(dbg_addr_i)) begin
         ram_we = 1'b1;
         ram_wa = dbg_addr_i;
         ram_wd = dbg_wdata_i;
      end
   end

   // Storage array, deliberately without reset (cleared by the sweep)
   always_ff @(posedge clk_i) begin
      if (ram_we) ram[ram_wa] <= ram_wd;
   end

   // Control state, clear counter and debug read register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         dbg_addr_q  <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
         if (dbg_acc) dbg_addr_q <= dbg_addr_i;
         if (state_q == DBG_RD)
            dbg_rdata_q <= is_zero(dbg_addr_q) ? '0 : ram[dbg_addr_q];
      end
   end

   // Registered read ports and W-stage forward flags, frozen on stall
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < NRD; k++) rd_q[k] <= '0;
         fw_w_q     <= '0;
         bypass_w_q <= '0;
      end else begin
         if (wr) bypass_w_q <= w_rd_value_i;
         if (!d_stall_i) begin
            for (int k = 0; k < NRD; k++) begin
               rd_q[k] <= is_zero(rf_rs_i[k*AW +: AW]) ? '0
                        : ram[rf_rs_i[k*AW +: AW]];
               fw_w_q[k] <= wr && (rf_rs_i[k*AW +: AW] == w_rd_i);
            end
         end
      end
   end

   // Operand mux: X forward, then W forward, then registered read
   always_comb begin
      x_rs_value_o = '0;
      for (int k = 0; k < NRD; k++) begin
         if (w_bypass_rd_write_i && (d_rs_i[k*AW +: AW] == w_rd_i)
             && !is_zero(w_rd_i))
            x_rs_value_o[k*XLEN +: XLEN] = w_bypass_rd_value_i;
         else if (fw_w_q[k])
            x_rs_value_o[k*XLEN +: XLEN] = bypass_w_q;
         else
            x_rs_value_o[k*XLEN +: XLEN] = rd_q[k];
      end
   end

   assign dbg_ack_o   = (state_q == DBG_ACK);
   assign dbg_rdata_o = dbg_rdata_q;
   assign init_busy_o = (state_q == INIT);

endmodule

// File: tb/tb_kmkz_regfile_np.sv
// tb_kmkz_regfile_np: directed checks of kmkz_regfile_np.
// Default build (A) plus a 16x16-bit, 3-port build (B).
module tb_kmkz_regfile_np;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   logic        a_rst, a_stall, a_store, a_bwr, a_req, a_we, a_ack, a_busy;
   logic [9:0]  a_rf_rs, a_d_rs;
   logic [63:0] a_x;
   logic [4:0]  a_w_rd, a_daddr;
   logic [31:0] a_w_val, a_b_val, a_wdata, a_rdata;

   logic        b_rst, b_stall, b_store, b_bwr, b_req, b_we, b_ack, b_busy;
   logic [11:0] b_rf_rs, b_d_rs;
   logic [47:0] b_x;
   logic [3:0]  b_w_rd, b_daddr;
   logic [15:0] b_w_val, b_b_val, b_wdata, b_rdata;

   kmkz_regfile_np u_a (
      .clk_i(clk_i), .rst_i(a_rst), .d_stall_i(a_stall),
      .rf_rs_i(a_rf_rs), .d_rs_i(a_d_rs), .x_rs_value_o(a_x),
      .w_rd_i(a_w_rd), .w_rd_value_i(a_w_val), .w_rd_store_i(a_store),
      .w_bypass_rd_write_i(a_bwr), .w_bypass_rd_value_i(a_b_val),
      .dbg_req_i(a_req), .dbg_we_i(a_we), .dbg_addr_i(a_daddr),
      .dbg_wdata_i(a_wdata), .dbg_ack_o(a_ack), .dbg_rdata_o(a_rdata),
      .init_busy_o(a_busy)
   );

   kmkz_regfile_np #(.XLEN(16), .NREGS(16), .NRD(3), .ZERO_REG(1)) u_b (
      .clk_i(clk_i), .rst_i(b_rst), .d_stall_i(b_stall),
      .rf_rs_i(b_rf_rs), .d_rs_i(b_d_rs), .x_rs_value_o(b_x),
      .w_rd_i(b_w_rd), .w_rd_value_i(b_w_val), .w_rd_store_i(b_store),
      .w_bypass_rd_write_i(b_bwr), .w_bypass_rd_value_i(b_b_val),
      .dbg_req_i(b_req), .dbg_we_i(b_we), .dbg_addr_i(b_daddr),
      .dbg_wdata_i(b_wdata), .dbg_ack_o(b_ack), .dbg_rdata_o(b_rdata),
      .init_busy_o(b_busy)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic a_dbg(input logic we, input logic [4:0] addr,
                        input logic [31:0] wd, output int lat);
      a_req = 1'b1; a_we = we; a_daddr = addr; a_wdata = wd;
      lat = 0;
      do begin tick(); lat++; end while (!a_ack && lat < 20);
      a_req = 1'b0;
      tick();
   endtask

   task automatic b_dbg(input logic we, input logic [3:0] addr,
                        input logic [15:0] wd, output int lat);
      b_req = 1'b1; b_we = we; b_daddr = addr; b_wdata = wd;
      lat = 0;
      do begin tick(); lat++; end while (!b_ack && lat < 20);
      b_req = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lat, acks;
      logic [63:0] acc;
      a_rst = 1'b1; a_stall = 0; a_store = 0; a_bwr = 0; a_req = 0; a_we = 0;
      a_rf_rs = '0; a_d_rs = '0; a_w_rd = '0; a_daddr = '0;
      a_w_val = '0; a_b_val = '0; a_wdata = '0;
      b_rst = 1'b1; b_stall = 0; b_store = 0; b_bwr = 0; b_req = 0; b_we = 0;
      b_rf_rs = '0; b_d_rs = '0; b_w_rd = '0; b_daddr = '0;
      b_w_val = '0; b_b_val = '0; b_wdata = '0;
      #2 a_rst = 1'b0; b_rst = 1'b0;
      #1;
      check("a_rst_x", a_x, 64'h0);
      check("a_rst_ack", a_ack, 1'b0);
      check("a_rst_rdata", a_rdata, 32'h0);
      check("a_rst_busy", a_busy, 1'b1);
      check("b_rst_busy", b_busy, 1'b1);
      repeat (2) tick();
      a_rst = 1'b1;
      n = 0;
      while (a_busy && n < 100) begin tick(); n++; end
      check("a_init_len", n, 32);

      acc = '0;
      for (int i = 0; i < 32; i++) begin
         a_rf_rs = {5'(31 - i), 5'(i)};
         tick();
         acc = acc | a_x;
      end
      check("a_all_clear", acc, 64'h0);

      a_rf_rs = {5'd6, 5'd5};
      a_w_rd = 5'd5; a_w_val = 32'hDEADBEEF; a_store = 1'b1;
      tick();
      a_store = 1'b0;
      check("a_wfwd_p0", a_x[31:0], 32'hDEADBEEF);
      check("a_wfwd_p1", a_x[63:32], 32'h0);
      tick();
      check("a_ram_p0", a_x[31:0], 32'hDEADBEEF);

      a_rf_rs = {5'd9, 5'd9};
      a_w_rd = 5'd9; a_w_val = 32'h11112222; a_store = 1'b1;
      tick();
      a_store = 1'b0;
      check("a_wfwd_both", a_x, {2{32'h11112222}});

      a_rf_rs = '0;
      a_w_rd = 5'd0; a_w_val = 32'hFFFFFFFF; a_store = 1'b1;
      tick();
      a_store = 1'b0;
      check("a_r0_fwd", a_x, 64'h0);
      tick();
      check("a_r0_ram", a_x, 64'h0);

      a_rf_rs = {5'd7, 5'd5};
      tick();
      a_d_rs = {5'd7, 5'd5};
      a_w_rd = 5'd7; a_bwr = 1'b1; a_b_val = 32'h12345678;
      #1;
      check("a_xfwd_p1", a_x, {32'h12345678, 32'hDEADBEEF});
      a_w_rd = 5'd5;
      #1;
      check("a_xfwd_p0", a_x, {32'h0, 32'h12345678});
      a_rf_rs = {5'd0, 5'd5};
      tick();
      a_d_rs = {5'd0, 5'd5}; a_w_rd = 5'd0;
      #1;
      check("a_xfwd_r0", a_x, {32'h0, 32'hDEADBEEF});
      a_bwr = 1'b0;

      a_rf_rs = {5'd0, 5'd12};
      a_w_rd = 5'd12; a_w_val = 32'hAAAA0001; a_store = 1'b1;
      tick();
      a_store = 1'b0;
      a_d_rs = {5'd0, 5'd12}; a_bwr = 1'b1; a_b_val = 32'hBBBB0002;
      #1;
      check("a_prio_x", a_x[31:0], 32'hBBBB0002);
      a_bwr = 1'b0;
      #1;
      check("a_prio_w", a_x[31:0], 32'hAAAA0001);
      a_d_rs = '0; a_w_rd = '0;

      a_stall = 1'b1;
      a_dbg(1'b1, 5'd3, 32'hA5A5A5A5, lat);
      check("a_dwr_lat", lat, 1);
      a_dbg(1'b0, 5'd3, 32'h0, lat);
      check("a_drd_lat", lat, 2);
      check("a_drd_data", a_rdata, 32'hA5A5A5A5);
      a_dbg(1'b0, 5'd5, 32'h0, lat);
      check("a_drd5_data", a_rdata, 32'hDEADBEEF);
      a_dbg(1'b1, 5'd0, 32'hFFFFFFFF, lat);
      check("a_dwr0_lat", lat, 1);
      a_dbg(1'b0, 5'd0, 32'h0, lat);
      check("a_drd0_lat", lat, 2);
      check("a_drd0_data", a_rdata, 32'h0);

      a_stall = 1'b0;
      a_req = 1'b1; a_we = 1'b1; a_daddr = 5'd4; a_wdata = 32'h0BADF00D;
      acks = 0;
      repeat (10) begin tick(); if (a_ack) acks++; end
      check("a_nostall_ack", acks, 0);
      a_stall = 1'b1;
      a_dbg(1'b1, 5'd4, 32'h0BADF00D, lat);
      check("a_stall_go_lat", lat, 1);

      a_w_rd = 5'd10; a_w_val = 32'hCAFE0010; a_store = 1'b1;
      a_req = 1'b1; a_we = 1'b1; a_daddr = 5'd8; a_wdata = 32'h00000808;
      tick();
      a_store = 1'b0;
      check("a_coll_ack1", a_ack, 1'b0);
      tick();
      check("a_coll_ack2", a_ack, 1'b1);
      a_req = 1'b0;
      tick();

      a_stall = 1'b0;
      a_rf_rs = {5'd10, 5'd8};
      tick();
      check("a_coll_data", a_x, {32'hCAFE0010, 32'h00000808});
      a_rf_rs = {5'd3, 5'd4};
      tick();
      check("a_dbg_data", a_x, {32'hA5A5A5A5, 32'h0BADF00D});

      a_stall = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_daddr = 5'd3;
      tick();
      check("a_mid_ack0", a_ack, 1'b0);
      a_rst = 1'b0;
      #1;
      check("a_mid_busy", a_busy, 1'b1);
      check("a_mid_x", a_x, 64'h0);
      a_req = 1'b0;
      tick();
      a_rst = 1'b1;
      n = 0; acks = 0;
      while (a_busy && n < 100) begin
         tick(); n++;
         if (a_ack) acks++;
      end
      check("a_reinit_len", n, 32);
      check("a_reinit_ack", acks, 0);
      check("a_reinit_rdata", a_rdata, 32'h0);
      a_stall = 1'b0;
      a_rf_rs = {5'd5, 5'd3};
      tick();
      check("a_reinit_clear", a_x, 64'h0);

      tick();
      b_rst = 1'b1;
      n = 0;
      while (b_busy && n < 100) begin tick(); n++; end
      check("b_init_len", n, 16);

      b_rf_rs = {4'd9, 4'd9, 4'd9};
      b_w_rd = 4'd9; b_w_val = 16'hBEEF; b_store = 1'b1;
      tick();
      b_store = 1'b0;
      check("b_wfwd3", b_x, {3{16'hBEEF}});
      b_rf_rs = {4'd2, 4'd1, 4'd9};
      tick();
      check("b_ram3", b_x, {16'h0, 16'h0, 16'hBEEF});
      b_d_rs = {4'd9, 4'd1, 4'd0};
      b_bwr = 1'b1; b_b_val = 16'h1234;
      #1;
      check("b_xfwd", b_x, {16'h1234, 16'h0, 16'hBEEF});
      b_bwr = 1'b0;

      b_stall = 1'b1;
      b_dbg(1'b0, 4'd9, 16'h0, lat);
      check("b_drd_lat", lat, 2);
      check("b_drd_data", b_rdata, 16'hBEEF);

      b_req = 1'b1; b_we = 1'b0; b_daddr = 4'd9;
      tick();
      b_rst = 1'b0;
      #1;
      check("b_mid_ack", b_ack, 1'b0);
      check("b_mid_busy", b_busy, 1'b1);
      b_req = 1'b0;
      tick();
      b_rst = 1'b1;
      n = 0; acks = 0;
      while (b_busy && n < 100) begin
         tick(); n++;
         if (b_ack) acks++;
      end
      check("b_reinit_len", n, 16);
      check("b_reinit_ack", acks, 0);
      check("b_reinit_rdata", b_rdata, 16'h0);
      b_stall = 1'b0;
      b_rf_rs = {4'd9, 4'd9, 4'd9};
      tick();
      check("b_reinit_clear", b_x, 48'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
